// File: rtl/dekatron_bcd_counter.sv
// Multi-digit BCD counter with per-digit ripple delay, modelling a chain of dekatron tubes.
// Optional build macro DEKATRON_COUNTER_SATURATE_EN: saturate at all-9s / all-0s instead of wrapping.
module dekatron_bcd_counter #(
  parameter int DIGITS      = 6,
  parameter int DIGIT_WIDTH = 4,
  parameter int STEP_DELAY  = 3
) (
  input  logic                          Clk,
  input  logic                          Rst,
  input  logic                          Request,
  input  logic [1:0]                    Op,
  input  logic [DIGITS*DIGIT_WIDTH-1:0] In,
  output logic                          Ready,
  output logic [DIGITS*DIGIT_WIDTH-1:0] Out,
  output logic                          Zero,
  output logic                          Overflow,
  output logic                          Error
);

  localparam int W     = DIGITS * DIGIT_WIDTH;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int TW    = (STEP_DELAY > 1) ? $clog2(STEP_DELAY) : 1;

  localparam logic [1:0] OP_INC = 2'b00;
  localparam logic [1:0] OP_DEC = 2'b01;
  localparam logic [1:0] OP_SET = 2'b10;
  localparam logic [1:0] OP_CLR = 2'b11;

  localparam logic [TW-1:0]    TIMER_LOAD = TW'(STEP_DELAY - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

  // DONE is folded into the finishing STEP edge, so it is never actually held.
  typedef enum logic [1:0] {IDLE, STEP, DONE} state_e;

  state_e                  state_q, state_d;
  logic [1:0]              op_q, op_d;
  logic [W-1:0]            in_q, in_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic [W-1:0]            out_q, out_d;
  logic                    zero_q, zero_d;
  logic                    overflow_q, overflow_d;
  logic                    error_q, error_d;

  logic [DIGIT_WIDTH-1:0]  digit, new_digit, fill;
  logic                    carry, finish, bcd_ok;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    in_d       = in_q;
    idx_d      = idx_q;
    timer_d    = timer_q;
    out_d      = out_q;
    zero_d     = zero_q;
    overflow_d = 1'b0;
    error_d    = 1'b0;
    finish     = 1'b0;
    carry      = 1'b0;
    new_digit  = '0;
    fill       = '0;
    digit      = out_q[idx_q*DIGIT_WIDTH +: DIGIT_WIDTH];

    bcd_ok = 1'b1;
    for (int j = 0; j < DIGITS; j++) begin
      if (in_q[j*DIGIT_WIDTH +: DIGIT_WIDTH] > DIGIT_WIDTH'(9)) bcd_ok = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (Request) begin
          op_d    = Op;
          in_d    = In;
          idx_d   = '0;
          timer_d = TIMER_LOAD;
          state_d = STEP;
        end
      end
      STEP: begin
        if (timer_q != '0) begin
          timer_d = timer_q - 1'b1;
        end else begin
          case (op_q)
            OP_INC, OP_DEC: begin
              if (op_q == OP_INC) begin
                carry     = (digit == DIGIT_WIDTH'(9));
                new_digit = carry ? '0 : digit + 1'b1;
                fill      = '0;
              end else begin
                carry     = (digit == '0);
                new_digit = carry ? DIGIT_WIDTH'(9) : digit - 1'b1;
                fill      = DIGIT_WIDTH'(9);
              end
`ifdef DEKATRON_COUNTER_SATURATE_EN
              // Ripple is only probed; the whole result lands when the carry stops.
              if (!carry) begin
                out_d[idx_q*DIGIT_WIDTH +: DIGIT_WIDTH] = new_digit;
                for (int j = 0; j < DIGITS; j++) begin
                  if (j < int'(idx_q)) out_d[j*DIGIT_WIDTH +: DIGIT_WIDTH] = fill;
                end
              end
`else
              out_d[idx_q*DIGIT_WIDTH +: DIGIT_WIDTH] = new_digit;
`endif
              if (carry && idx_q != IDX_LAST) begin
                idx_d   = idx_q + 1'b1;
                timer_d = TIMER_LOAD;
              end else begin
                overflow_d = carry;
                finish     = 1'b1;
              end
            end
            OP_SET: begin
              if (bcd_ok) out_d = in_q;
              else        error_d = 1'b1;
              finish = 1'b1;
            end
            default: begin
              out_d  = '0;
              finish = 1'b1;
            end
          endcase
          if (finish) begin
            zero_d  = (out_d == '0);
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q    <= IDLE;
      op_q       <= OP_INC;
      in_q       <= '0;
      idx_q      <= '0;
      timer_q    <= '0;
      out_q      <= '0;
      zero_q     <= 1'b1;
      overflow_q <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      in_q       <= in_d;
      idx_q      <= idx_d;
      timer_q    <= timer_d;
      out_q      <= out_d;
      zero_q     <= zero_d;
      overflow_q <= overflow_d;
      error_q    <= error_d;
    end
  end

  assign Ready    = (state_q == IDLE);
  assign Out      = out_q;
  assign Zero     = zero_q;
  assign Overflow = overflow_q;
  assign Error    = error_q;

endmodule

// File: tb/tb_dekatron_bcd_counter.sv
// Directed bench for dekatron_bcd_counter at DIGITS=3, STEP_DELAY=2.
module tb_dekatron_bcd_counter;

  localparam int DIGITS = 3;
  localparam int SD     = 2;
  localparam int W      = DIGITS * 4;

  logic         Clk = 1'b0;
  logic         Rst = 1'b1;
  logic         Request = 1'b0;
  logic [1:0]   Op = 2'b00;
  logic [W-1:0] In = '0;
  logic         Ready, Zero, Overflow, Error;
  logic [W-1:0] Out;

  int n_checks = 0;
  int n_pass   = 0;

  int           lat;
  logic [W-1:0] out_at2;
  logic         ovf_done, err_done, ovf_next, err_next, pulse_busy;

  dekatron_bcd_counter #(.DIGITS(DIGITS), .DIGIT_WIDTH(4), .STEP_DELAY(SD)) dut (
    .Clk(Clk), .Rst(Rst), .Request(Request), .Op(Op), .In(In),
    .Ready(Ready), .Out(Out), .Zero(Zero), .Overflow(Overflow), .Error(Error)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Called #1 after a rising edge; returns with the same phase.
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] val, input bit hold);
    Request = 1'b1; Op = op; In = val;
    @(posedge Clk); #1;
    if (!hold) Request = 1'b0;
    lat = -1; out_at2 = 'x; pulse_busy = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge Clk); #1;
      if (c == 2) out_at2 = Out;
      if (Ready) begin
        lat = c;
        Request = 1'b0;
        break;
      end
      if (Overflow || Error) pulse_busy = 1'b1;
    end
    if (lat < 0) check("timeout", 32'(Ready), 32'd1);
    ovf_done = Overflow; err_done = Error;
    @(posedge Clk); #1;
    ovf_next = Overflow; err_next = Error;
  endtask

  initial begin
    logic [W-1:0] prev;
    #12; Rst = 1'b0;
    @(posedge Clk); #1;
    check("rst_out", 32'(Out), 32'h000);
    check("rst_zero", 32'(Zero), 32'd1);
    check("rst_ready", 32'(Ready), 32'd1);
    check("rst_ovf", 32'(Overflow), 32'd0);
    check("rst_err", 32'(Error), 32'd0);

    // inc 000 with Request held through busy: single operation only
    run_op(2'b00, '0, 1'b1);
    check("inc0_lat", 32'(lat), 32'd2);
    check("inc0_out", 32'(Out), 32'h001);
    check("inc0_zero", 32'(Zero), 32'd0);
    check("inc0_ready_after", 32'(Ready), 32'd1);

    run_op(2'b10, 12'h009, 1'b0);
    check("set009_out", 32'(Out), 32'h009);
    run_op(2'b00, '0, 1'b0);
`ifdef DEKATRON_COUNTER_SATURATE_EN
    check("inc9_mid", 32'(out_at2), 32'h009);
`else
    check("inc9_mid", 32'(out_at2), 32'h000);
`endif
    check("inc9_lat", 32'(lat), 32'd4);
    check("inc9_out", 32'(Out), 32'h010);
    check("inc9_ovf", 32'(ovf_done), 32'd0);

    run_op(2'b10, 12'h999, 1'b0);
    run_op(2'b00, '0, 1'b0);
    check("inc999_lat", 32'(lat), 32'd6);
`ifdef DEKATRON_COUNTER_SATURATE_EN
    check("inc999_out", 32'(Out), 32'h999);
    check("inc999_zero", 32'(Zero), 32'd0);
`else
    check("inc999_out", 32'(Out), 32'h000);
    check("inc999_zero", 32'(Zero), 32'd1);
`endif
    check("inc999_ovf", 32'(ovf_done), 32'd1);
    check("inc999_ovf_end", 32'(ovf_next), 32'd0);
    check("inc999_busy_pulse", 32'(pulse_busy), 32'd0);

    run_op(2'b10, 12'h100, 1'b0);
    run_op(2'b01, '0, 1'b0);
    check("dec100_lat", 32'(lat), 32'd6);
    check("dec100_out", 32'(Out), 32'h099);
    check("dec100_ovf", 32'(ovf_done), 32'd0);

    run_op(2'b11, '0, 1'b0);
    run_op(2'b01, '0, 1'b0);
    check("dec0_lat", 32'(lat), 32'd6);
`ifdef DEKATRON_COUNTER_SATURATE_EN
    check("dec0_out", 32'(Out), 32'h000);
    prev = 12'h000;
`else
    check("dec0_out", 32'(Out), 32'h999);
    prev = 12'h999;
`endif
    check("dec0_ovf", 32'(ovf_done), 32'd1);

    run_op(2'b10, 12'h1A3, 1'b0);
    check("setbad_lat", 32'(lat), 32'd2);
    check("setbad_err", 32'(err_done), 32'd1);
    check("setbad_err_end", 32'(err_next), 32'd0);
    check("setbad_ovf", 32'(ovf_done), 32'd0);
    check("setbad_out", 32'(Out), 32'(prev));

    run_op(2'b10, 12'h123, 1'b0);
    check("set123_lat", 32'(lat), 32'd2);
    check("set123_out", 32'(Out), 32'h123);
    check("set123_err", 32'(err_done), 32'd0);

    run_op(2'b11, '0, 1'b0);
    check("clr_lat", 32'(lat), 32'd2);
    check("clr_out", 32'(Out), 32'h000);
    check("clr_zero", 32'(Zero), 32'd1);

    // Reset in the middle of a rippling inc on 999
    run_op(2'b10, 12'h999, 1'b0);
    Request = 1'b1; Op = 2'b00;
    @(posedge Clk); #1; Request = 1'b0;
    @(posedge Clk); @(posedge Clk); #3;
    check("abort_busy", 32'(Ready), 32'd0);
    Rst = 1'b1; #1;
    check("abort_out", 32'(Out), 32'h000);
    check("abort_ready", 32'(Ready), 32'd1);
    check("abort_zero", 32'(Zero), 32'd1);
    repeat (8) begin
      @(posedge Clk); #1;
      if (Overflow) check("abort_ovf", 32'(Overflow), 32'd0);
    end
    Rst = 1'b0;
    @(posedge Clk); #1;
    check("abort_ovf_final", 32'(Overflow), 32'd0);
    check("abort_out_final", 32'(Out), 32'h000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
